// File: rtl/ctrl_secuencia_param.sv
// rtl/ctrl_secuencia_param.sv - parametrised frame sequencer for the term-evaluation datapath
// Ports: clk, reset (async, active-high); Bandera start request; modo_cont free-running
// frame restart; abortar synchronous abort; sel_const/sel_fun term selects; sel_acum
// load(0)/accumulate(1); en_acum accumulator write enable; ocupado frame in progress;
// Band_Listo one-cycle frame-complete pulse. All outputs come straight from flops.
module ctrl_secuencia_param #(
    parameter int N_TERM = 6,
    parameter int CW     = 3,
    parameter int N_FUN  = 3,
    parameter int FW     = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Bandera,
    input  logic          modo_cont,
    input  logic          abortar,
    output logic [CW-1:0] sel_const,
    output logic [FW-1:0] sel_fun,
    output logic          sel_acum,
    output logic          en_acum,
    output logic          ocupado,
    output logic          Band_Listo
);

    localparam int KW = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_TERM - 1);
    localparam logic [FW-1:0] F_LAST = FW'(N_FUN - 1);

    if (N_TERM < 2 || N_TERM > (1 << CW) || N_FUN < 1 || N_FUN > (1 << FW)) begin : g_bad_param
        $fatal(1, "ctrl_secuencia_param: illegal N_TERM/CW/N_FUN/FW combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [FW-1:0] f_q, f_d;

    logic [CW-1:0] sel_const_q, sel_const_d;
    logic [FW-1:0] sel_fun_q, sel_fun_d;
    logic          sel_acum_q, sel_acum_d;
    logic          en_acum_q, en_acum_d;
    logic          ocupado_q, ocupado_d;
    logic          band_listo_q, band_listo_d;

    // Next state and counters. The function counter advances alongside k and
    // wraps on its own, so sel_fun = k mod N_FUN without any divider.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        f_d     = f_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Bandera) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                    f_d     = '0;
                end
            end
            ST_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                    k_d     = '0;
                    f_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                    f_d = (f_q == F_LAST) ? '0 : f_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = modo_cont ? ST_RUN : ST_IDLE;
                k_d     = '0;
                f_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
                f_d     = '0;
            end
        endcase
        if (abortar) begin
            state_d = ST_IDLE;
            k_d     = '0;
            f_d     = '0;
        end
    end

    // Outputs are decoded from the *next* state so that registering them puts
    // term k on the lines right after the edge that enters it.
    always_comb begin
        sel_const_d  = '0;
        sel_fun_d    = '0;
        sel_acum_d   = 1'b0;
        en_acum_d    = 1'b0;
        ocupado_d    = 1'b0;
        band_listo_d = 1'b0;
        unique case (state_d)
            ST_RUN: begin
                sel_const_d = CW'(k_d);
                sel_fun_d   = f_d;
                sel_acum_d  = (k_d != '0);
                en_acum_d   = 1'b1;
                ocupado_d   = 1'b1;
            end
            ST_DONE: begin
                ocupado_d    = 1'b1;
                band_listo_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            f_q          <= '0;
            sel_const_q  <= '0;
            sel_fun_q    <= '0;
            sel_acum_q   <= 1'b0;
            en_acum_q    <= 1'b0;
            ocupado_q    <= 1'b0;
            band_listo_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            f_q          <= f_d;
            sel_const_q  <= sel_const_d;
            sel_fun_q    <= sel_fun_d;
            sel_acum_q   <= sel_acum_d;
            en_acum_q    <= en_acum_d;
            ocupado_q    <= ocupado_d;
            band_listo_q <= band_listo_d;
        end
    end

    assign sel_const  = sel_const_q;
    assign sel_fun    = sel_fun_q;
    assign sel_acum   = sel_acum_q;
    assign en_acum    = en_acum_q;
    assign ocupado    = ocupado_q;
    assign Band_Listo = band_listo_q;

endmodule

// File: tb/tb_ctrl_secuencia_param.sv
// tb/tb_ctrl_secuencia_param.sv - self-checking bench for ctrl_secuencia_param
module tb_ctrl_secuencia_param;

    logic clk, reset, Bandera, modo_cont, abortar;

    logic [2:0] sc0, sc1;
    logic [1:0] sf0, sf1;
    logic       sa0, sa1, ea0, ea1, oc0, oc1, bl0, bl1;

    ctrl_secuencia_param #(.N_TERM(6), .CW(3), .N_FUN(3), .FW(2)) dut6 (
        .clk(clk), .reset(reset), .Bandera(Bandera), .modo_cont(modo_cont), .abortar(abortar),
        .sel_const(sc0), .sel_fun(sf0), .sel_acum(sa0), .en_acum(ea0), .ocupado(oc0),
        .Band_Listo(bl0)
    );

    ctrl_secuencia_param #(.N_TERM(8), .CW(3), .N_FUN(4), .FW(2)) dut8 (
        .clk(clk), .reset(reset), .Bandera(Bandera), .modo_cont(modo_cont), .abortar(abortar),
        .sel_const(sc1), .sel_fun(sf1), .sel_acum(sa1), .en_acum(ea1), .ocupado(oc1),
        .Band_Listo(bl1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference position in the frame: -1 idle, 0..n-1 term k, n done.
    int pos6 = -1;
    int pos8 = -1;

    wire [8:0] out6 = {sc0, sf0, sa0, ea0, oc0, bl0};
    wire [8:0] out8 = {sc1, sf1, sa1, ea1, oc1, bl1};

    function automatic int next_pos(int p, int n, logic b, logic m, logic a);
        if (a) return -1;
        if (p < 0) return b ? 0 : -1;
        if (p < n) return p + 1;
        return m ? 0 : -1;
    endfunction

    function automatic logic [8:0] exp_vec(int p, int n, int nf);
        logic [2:0] c;
        logic [1:0] f;
        if (p < 0) return 9'd0;
        if (p == n) return 9'b000_00_0_0_1_1;
        c = 3'(p);
        f = 2'(p % nf);
        return {c, f, (p > 0), 1'b1, 1'b1, 1'b0};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("model_n6", int'(out6), int'(exp_vec(pos6, 6, 3)));
        chk("model_n8", int'(out8), int'(exp_vec(pos8, 8, 4)));
    endtask

    // Called at a falling edge: drive inputs, take the rising edge, check at the next fall.
    task automatic cycle(input logic b, input logic m, input logic a);
        Bandera   = b;
        modo_cont = m;
        abortar   = a;
        @(posedge clk);
        pos6 = next_pos(pos6, 6, b, m, a);
        pos8 = next_pos(pos8, 8, b, m, a);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Reset pulse placed between clock edges; outputs must clear before any edge.
    task automatic async_reset_mid();
        Bandera   = 1'b0;
        modo_cont = 1'b0;
        abortar   = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_reset_n6", int'(out6), 0);
        chk("async_reset_n8", int'(out8), 0);
        pos6 = -1;
        pos8 = -1;
        #1 reset = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic       b;
        logic       m;
        logic       a;
        logic [8:0] ev;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic b, logic m, logic a, logic [2:0] c, logic [1:0] f,
                                logic ac, logic en, logic oc, logic bl);
        vec_t v;
        v.b  = b;
        v.m  = m;
        v.a  = a;
        v.ev = {c, f, ac, en, oc, bl};
        return v;
    endfunction

    initial begin
        int bl8_cyc;
        logic [31:0] bl_mask;
        logic m;

        // Single frame from one Bandera pulse, then idle (rows 0..9)
        tbl[0]  = mk(1, 0, 0, 3'd0, 2'd0, 0, 1, 1, 0);
        tbl[1]  = mk(0, 0, 0, 3'd1, 2'd1, 1, 1, 1, 0);
        tbl[2]  = mk(0, 0, 0, 3'd2, 2'd2, 1, 1, 1, 0);
        tbl[3]  = mk(0, 0, 0, 3'd3, 2'd0, 1, 1, 1, 0);
        tbl[4]  = mk(0, 0, 0, 3'd4, 2'd1, 1, 1, 1, 0);
        tbl[5]  = mk(0, 0, 0, 3'd5, 2'd2, 1, 1, 1, 0);
        tbl[6]  = mk(0, 0, 0, 3'd0, 2'd0, 0, 0, 1, 1);
        tbl[7]  = mk(0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0);
        // Bandera re-pulsed while sel_const=2 is ignored (rows 10..17)
        tbl[10] = mk(1, 0, 0, 3'd0, 2'd0, 0, 1, 1, 0);
        tbl[11] = mk(0, 0, 0, 3'd1, 2'd1, 1, 1, 1, 0);
        tbl[12] = mk(0, 0, 0, 3'd2, 2'd2, 1, 1, 1, 0);
        tbl[13] = mk(1, 0, 0, 3'd3, 2'd0, 1, 1, 1, 0);
        tbl[14] = mk(0, 0, 0, 3'd4, 2'd1, 1, 1, 1, 0);
        tbl[15] = mk(0, 0, 0, 3'd5, 2'd2, 1, 1, 1, 0);
        tbl[16] = mk(0, 0, 0, 3'd0, 2'd0, 0, 0, 1, 1);
        tbl[17] = mk(0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0);

        reset     = 1'b1;
        Bandera   = 1'b0;
        modo_cont = 1'b0;
        abortar   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;
        idle_cycles(2);

        bl8_cyc = -1;
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].b, tbl[i].m, tbl[i].a);
            chk($sformatf("table_row%0d", i), int'(out6), int'(tbl[i].ev));
            if (i < 10 && bl1 && bl8_cyc < 0) bl8_cyc = i + 1;
        end
        chk("n8_band_listo_cycle", bl8_cyc, 9);
        idle_cycles(3);

        // Continuous mode: frames back to back, modo_cont dropped during frame 2
        bl_mask = '0;
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 2; i <= 17; i++) begin
            m = (i <= 9);
            cycle(1'b0, m, 1'b0);
            if (bl0) bl_mask[i] = 1'b1;
            if (i == 8) begin
                chk("cont_restart_const", int'(sc0), 0);
                chk("cont_restart_acum", int'({sa0, ea0}), 1);
            end
            if (i == 15) chk("cont_stop_ocupado", int'(oc0), 0);
        end
        chk("cont_band_listo_mask", int'(bl_mask), 32'h0000_4080);
        idle_cycles(3);

        // Abort at sel_const=3
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(3);
        chk("abort_at_k3", int'(sc0), 3);
        cycle(1'b0, 1'b1, 1'b1);
        chk("abort_clears", int'(out6), 0);
        bl_mask = '0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (bl0 || bl1) bl_mask[i] = 1'b1;
        end
        chk("abort_no_band_listo", int'(bl_mask), 0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("abort_restart", int'({sc0, sa0, ea0}), 1);
        idle_cycles(10);

        // Asynchronous reset while sel_const=4
        cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(4);
        chk("reset_at_k4", int'(sc0), 4);
        async_reset_mid();
        idle_cycles(3);
        chk("reset_stays_idle", int'(oc0), 0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("reset_restart", int'({sc0, ea0, oc0}), 3);
        idle_cycles(10);

        // Randomised traffic against the reference model
        m = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) m = ~m;
            if ($urandom_range(0, 249) == 0) async_reset_mid();
            else cycle(($urandom_range(0, 2) == 0), m, ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_secuencia_param.md
Name: ctrl_secuencia_param

Overview:
Parametrised sequencer that drives the constant-select, function-select and accumulator-control lines of the term-evaluation datapath.
- One frame = N_TERM evaluation steps.
- Started by a Bandera pulse; signals completion with Band_Listo.
- Adds continuous (free-running) mode, synchronous abort, busy flag and explicit accumulator enable.
- Successor to the fixed 6-step mux controller, with a configurable term count and function-cycle length.

Parameters:
N_TERM, 6, terms per frame; legal range 2..2^CW.
CW, 3, width of sel_const.
N_FUN, 3, length of the function cycle; sel_fun repeats 0..N_FUN-1; legal range 1..2^FW.
FW, 2, width of sel_fun.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
Bandera  in  1  start request, sampled on clk.
modo_cont  in  1  1 = restart the frame automatically after DONE.
abortar  in  1  synchronous abort.
sel_const  out  CW  constant index of the current term.
sel_fun  out  FW  function index of the current term.
sel_acum  out  1  0 = load accumulator, 1 = accumulate.
en_acum  out  1  accumulator write enable.
ocupado  out  1  high while a frame is in progress (RUN or DONE).
Band_Listo  out  1  one-cycle frame-complete pulse.

Behaviour:
- Reset: asynchronous and active-high. It forces state IDLE and drives all outputs and counters to 0. Reset has priority over every other input.
- All outputs are registered; none is combinational from the inputs.
- States: IDLE, RUN, DONE.
- Term counter k: width $clog2(N_TERM). Function counter f: wraps N_FUN-1 -> 0. No division is used.
- IDLE: all outputs 0.
  - Bandera=1 at edge E0 -> RUN with k=0, f=0.
- RUN, term k (outputs visible after edge E0+k):
  - sel_const = k.
  - sel_fun = f = k mod N_FUN.
  - en_acum = 1; ocupado = 1.
  - sel_acum = 0 for k=0 (load), 1 for k>0 (accumulate).
- RUN transitions:
  - k < N_TERM-1: k++ and f advances with wrap.
  - k = N_TERM-1: go to DONE.
- DONE (after edge E0+N_TERM), lasts exactly one cycle:
  - Band_Listo = 1; ocupado = 1; en_acum = 0; sel_* = 0.
  - modo_cont=1 -> RUN with k=0, f=0 (one-cycle gap between frames).
  - modo_cont=0 -> IDLE.
- Latency: Band_Listo rises N_TERM cycles after the start edge. Frame period in continuous mode is N_TERM+1 cycles.
- Bandera in RUN or DONE is ignored: no restart and no queueing. Bandera held high in IDLE starts one frame per IDLE visit.
- abortar=1 in any state:
  - Next state is IDLE; all outputs go to 0 at the next edge.
  - Band_Listo is not asserted.
  - abortar has priority over Bandera and over modo_cont.
- modo_cont is sampled only in DONE; changes during RUN have no effect on the current frame.
- Reset asserted mid-frame: outputs clear immediately, without waiting for a clock edge. After release the block waits in IDLE for a fresh Bandera.
- Illegal parameters (N_TERM<2, N_TERM>2^CW, N_FUN>2^FW) are a fatal elaboration error.

Test Plan:
1. Defaults, Bandera pulse at edge 0.
   - sel_const 0..5 on cycles 1..6; sel_fun 0,1,2,0,1,2; sel_acum 0,1,1,1,1,1; en_acum=1.
   - Band_Listo=1 only on cycle 7; ocupado=1 on cycles 1..7; IDLE from cycle 8.
2. modo_cont=1 with defaults.
   - Band_Listo on cycles 7 and 14; sel_const=0 and sel_acum=0 on cycle 8.
   - modo_cont dropped during frame 2 -> IDLE after cycle 14.
3. abortar at sel_const=3.
   - Next cycle: all outputs 0 and ocupado=0; no Band_Listo ever appears.
   - A later Bandera restarts at k=0.
4. Bandera re-pulsed at sel_const=2.
   - Sequence continues 3,4,5; a single Band_Listo on cycle 7.
5. Reset asserted asynchronously mid-cycle at sel_const=4.
   - Outputs 0 before the next clk edge; after release the block stays IDLE until Bandera.
6. N_TERM=8, CW=3, N_FUN=4, FW=2.
   - sel_fun 0,1,2,3,0,1,2,3; sel_const 0..7; Band_Listo on cycle 9.
